// File: rtl/cache_stats_unit_if.sv
// rtl/cache_stats_unit_if.sv - command and report-stream handshake bundle for cache_stats_unit
interface cache_stats_unit_if #(
    parameter int counterWidth = 32
) ();
    logic                    cmdValid;
    logic [1:0]              cmd;
    logic                    cmdReady;
    logic                    outValid;
    logic                    outReady;
    logic [1:0]              outIndex;
    logic [counterWidth-1:0] outData;
    logic                    outLast;

    modport master (
        output cmdValid, cmd, outReady,
        input  cmdReady, outValid, outIndex, outData, outLast
    );

    modport slave (
        input  cmdValid, cmd, outReady,
        output cmdReady, outValid, outIndex, outData, outLast
    );
endinterface

// File: rtl/cache_stats_unit.sv
// rtl/cache_stats_unit.sv - saturating L2 hit/miss/read/write event counters with snapshot and report stream
module cache_stats_unit #(
    parameter int channels     = 4,
    parameter int counterWidth = 32
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic [channels-1:0] hitEvent,
    input  logic [channels-1:0] missEvent,
    input  logic [channels-1:0] readEvent,
    input  logic [channels-1:0] writeEvent,
    output logic [3:0]          overflow,
    output logic                conflict,
    cache_stats_unit_if.slave   bus
);
    localparam int incW = $clog2(channels + 1);

    localparam logic [1:0] CMD_SNAPSHOT       = 2'd0;
    localparam logic [1:0] CMD_CLEAR          = 2'd1;
    localparam logic [1:0] CMD_SNAPSHOT_CLEAR = 2'd2;
    localparam logic [1:0] CMD_PRINT          = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stateType;

    stateType state;
    stateType nextState;

    logic [counterWidth-1:0] count [4];
    logic [counterWidth-1:0] snap  [4];
    logic [channels-1:0]     ev    [4];
    logic [incW-1:0]         inc   [4];
    logic [counterWidth:0]   sum   [4];
    logic [3:0]              satBits;
    logic [1:0]              beat;

    logic accept;
    logic doSnap;
    logic doClear;
    logic doPrint;
    logic beatTaken;

    function automatic logic [incW-1:0] popcount(input logic [channels-1:0] v);
        logic [incW-1:0] n;
        n = '0;
        for (int i = 0; i < channels; i++) begin
            n = n + incW'(v[i]);
        end
        return n;
    endfunction

    assign ev[0] = hitEvent;
    assign ev[1] = missEvent;
    assign ev[2] = readEvent;
    assign ev[3] = writeEvent;

    // One extra sum bit exposes saturation without ever letting a counter wrap.
    always_comb begin
        satBits = '0;
        for (int k = 0; k < 4; k++) begin
            inc[k]     = popcount(ev[k]);
            sum[k]     = {1'b0, count[k]} + (counterWidth + 1)'(inc[k]);
            satBits[k] = sum[k][counterWidth];
        end
    end

    assign accept    = bus.cmdValid && bus.cmdReady;
    assign doSnap    = accept && (bus.cmd == CMD_SNAPSHOT || bus.cmd == CMD_SNAPSHOT_CLEAR);
    assign doClear   = accept && (bus.cmd == CMD_CLEAR || bus.cmd == CMD_SNAPSHOT_CLEAR);
    assign doPrint   = accept && (bus.cmd == CMD_PRINT);
    assign beatTaken = bus.outValid && bus.outReady;

    // A clear reloads with this cycle's increment so concurrent events are kept.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < 4; k++) begin
                count[k] <= '0;
            end
            overflow <= '0;
            conflict <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (doClear) begin
                    count[k] <= counterWidth'(inc[k]);
                end else if (satBits[k]) begin
                    count[k] <= '1;
                end else begin
                    count[k] <= sum[k][counterWidth-1:0];
                end
            end
            overflow <= doClear ? 4'b0000 : (overflow | satBits);
            conflict <= (doClear ? 1'b0 : conflict) | (|(hitEvent & missEvent));
        end
    end

    // Snapshot captures the pre-increment counter values.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < 4; k++) begin
                snap[k] <= '0;
            end
        end else if (doSnap) begin
            for (int k = 0; k < 4; k++) begin
                snap[k] <= count[k];
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            beat <= 2'd0;
        end else if (doPrint) begin
            beat <= 2'd0;
        end else if (beatTaken) begin
            beat <= beat + 2'd1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (doPrint) nextState = STREAM;
            STREAM:  if (beatTaken && beat == 2'd3) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Snapshot registers cannot change while streaming, so the beat index alone holds the data.
    always_comb begin
        bus.cmdReady = (state == IDLE);
        bus.outValid = (state == STREAM);
        bus.outIndex = beat;
        bus.outData  = snap[beat];
        bus.outLast  = (state == STREAM) && (beat == 2'd3);
    end
endmodule
